// File: rtl/os_systolic_tile.sv
// Output-stationary signed MAC tile: internal diagonal skew, self-sequenced
// IDLE/COMPUTE/FLUSH/DRAIN, row-per-cycle valid/ready drain with optional ReLU.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for i_start; accumulators cleared on start
// COMPUTE | o_ready=1, accepting k_len slices into the skew network
// FLUSH   | S_HEIGHT+S_WIDTH-1 cycles for the last slice to reach the far PE
// DRAIN   | o_valid=1, one accumulator row per i_ready handshake
module os_systolic_tile #(
    parameter int DATA_WIDTH = 8,
    parameter int S_HEIGHT   = 4,
    parameter int S_WIDTH    = 4,
    parameter int MAX_K      = 64,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(MAX_K)
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic                                         i_start,
    input  logic [$clog2(MAX_K+1)-1:0]                   i_k_len,
    input  logic                                         i_relu_en,
    input  logic                                         i_valid,
    output logic                                         o_ready,
    input  logic [S_HEIGHT*DATA_WIDTH-1:0]               i_ifmap,
    input  logic [S_WIDTH*DATA_WIDTH-1:0]                i_weight,
    output logic                                         o_valid,
    input  logic                                         i_ready,
    output logic [S_WIDTH*ACC_WIDTH-1:0]                 o_ofmap,
    output logic [((S_HEIGHT>1)?$clog2(S_HEIGHT):1)-1:0] o_row,
    output logic                                         o_last,
    output logic                                         o_busy,
    output logic                                         o_done
);

    localparam int KW   = $clog2(MAX_K+1);
    localparam int RW   = (S_HEIGHT > 1) ? $clog2(S_HEIGHT) : 1;
    localparam int FW   = $clog2(S_HEIGHT+S_WIDTH);
    localparam int A_SK = (S_HEIGHT > 1) ? S_HEIGHT*(S_HEIGHT-1)/2 : 1;
    localparam int B_SK = (S_WIDTH > 1) ? S_WIDTH*(S_WIDTH-1)/2 : 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DRAIN} state_t;

    state_t          state;
    logic [KW-1:0]   k_rem;
    logic [FW-1:0]   flush_cnt;
    logic [RW-1:0]   ptr;
    logic            relu_q;
    logic            ready_q;
    logic            valid_q;
    logic            busy_q;
    logic            done_q;

    logic [KW-1:0]   k_eff;
    logic            accept;
    logic            clr_acc;

    assign k_eff   = (i_k_len > KW'(MAX_K)) ? KW'(MAX_K) : i_k_len;
    assign accept  = i_valid && ready_q;
    assign clr_acc = (state == IDLE) && i_start;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            k_rem     <= '0;
            flush_cnt <= '0;
            ptr       <= '0;
            relu_q    <= 1'b0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        k_rem  <= k_eff;
                        relu_q <= i_relu_en;
                        busy_q <= 1'b1;
                        ptr    <= '0;
                        if (k_eff == '0) begin
                            state   <= DRAIN;
                            valid_q <= 1'b1;
                        end else begin
                            state   <= COMPUTE;
                            ready_q <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (accept) begin
                        k_rem <= k_rem - KW'(1);
                        if (k_rem == KW'(1)) begin
                            state     <= FLUSH;
                            ready_q   <= 1'b0;
                            flush_cnt <= FW'(S_HEIGHT+S_WIDTH-2);
                        end
                    end
                end
                FLUSH: begin
                    // down-counter reaching zero marks the far PE's last update edge
                    if (flush_cnt == '0) begin
                        state   <= DRAIN;
                        valid_q <= 1'b1;
                        ptr     <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - FW'(1);
                    end
                end
                DRAIN: begin
                    if (i_ready) begin
                        if (ptr == RW'(S_HEIGHT-1)) begin
                            state   <= IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            ptr     <= '0;
                        end else begin
                            ptr <= ptr + RW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Skew lines packed as triangles: lane r occupies r entries starting at r*(r-1)/2.
    logic [DATA_WIDTH-1:0] a_sk   [A_SK];
    logic                  a_sk_v [A_SK];
    logic [DATA_WIDTH-1:0] b_sk   [B_SK];
    logic                  b_sk_v [B_SK];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < A_SK; i++) begin
                a_sk[i]   <= '0;
                a_sk_v[i] <= 1'b0;
            end
            for (int i = 0; i < B_SK; i++) begin
                b_sk[i]   <= '0;
                b_sk_v[i] <= 1'b0;
            end
        end else begin
            for (int r = 1; r < S_HEIGHT; r++) begin
                a_sk[r*(r-1)/2]   <= i_ifmap[r*DATA_WIDTH +: DATA_WIDTH];
                a_sk_v[r*(r-1)/2] <= accept;
                for (int i = 1; i < r; i++) begin
                    a_sk[r*(r-1)/2+i]   <= a_sk[r*(r-1)/2+i-1];
                    a_sk_v[r*(r-1)/2+i] <= a_sk_v[r*(r-1)/2+i-1];
                end
            end
            for (int c = 1; c < S_WIDTH; c++) begin
                b_sk[c*(c-1)/2]   <= i_weight[c*DATA_WIDTH +: DATA_WIDTH];
                b_sk_v[c*(c-1)/2] <= accept;
                for (int i = 1; i < c; i++) begin
                    b_sk[c*(c-1)/2+i]   <= b_sk[c*(c-1)/2+i-1];
                    b_sk_v[c*(c-1)/2+i] <= b_sk_v[c*(c-1)/2+i-1];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0]        a_edge  [S_HEIGHT];
    logic                         av_edge [S_HEIGHT];
    logic [DATA_WIDTH-1:0]        b_edge  [S_WIDTH];
    logic                         bv_edge [S_WIDTH];

    logic [DATA_WIDTH-1:0]        a_pipe  [S_HEIGHT][S_WIDTH];
    logic                         av_pipe [S_HEIGHT][S_WIDTH];
    logic [DATA_WIDTH-1:0]        b_pipe  [S_HEIGHT][S_WIDTH];
    logic                         bv_pipe [S_HEIGHT][S_WIDTH];
    logic [DATA_WIDTH-1:0]        a_src   [S_HEIGHT][S_WIDTH];
    logic                         av_src  [S_HEIGHT][S_WIDTH];
    logic [DATA_WIDTH-1:0]        b_src   [S_HEIGHT][S_WIDTH];
    logic                         bv_src  [S_HEIGHT][S_WIDTH];
    logic signed [2*DATA_WIDTH-1:0] prod  [S_HEIGHT][S_WIDTH];
    logic signed [ACC_WIDTH-1:0]  acc     [S_HEIGHT][S_WIDTH];

    always_comb begin
        a_edge[0]  = i_ifmap[DATA_WIDTH-1:0];
        av_edge[0] = accept;
        for (int r = 1; r < S_HEIGHT; r++) begin
            a_edge[r]  = a_sk[r*(r-1)/2+r-1];
            av_edge[r] = a_sk_v[r*(r-1)/2+r-1];
        end
        b_edge[0]  = i_weight[DATA_WIDTH-1:0];
        bv_edge[0] = accept;
        for (int c = 1; c < S_WIDTH; c++) begin
            b_edge[c]  = b_sk[c*(c-1)/2+c-1];
            bv_edge[c] = b_sk_v[c*(c-1)/2+c-1];
        end
    end

    always_comb begin
        for (int r = 0; r < S_HEIGHT; r++) begin
            a_src[r][0]  = a_edge[r];
            av_src[r][0] = av_edge[r];
            for (int c = 1; c < S_WIDTH; c++) begin
                a_src[r][c]  = a_pipe[r][c-1];
                av_src[r][c] = av_pipe[r][c-1];
            end
        end
        for (int c = 0; c < S_WIDTH; c++) begin
            b_src[0][c]  = b_edge[c];
            bv_src[0][c] = bv_edge[c];
            for (int r = 1; r < S_HEIGHT; r++) begin
                b_src[r][c]  = b_pipe[r-1][c];
                bv_src[r][c] = bv_pipe[r-1][c];
            end
        end
        for (int r = 0; r < S_HEIGHT; r++) begin
            for (int c = 0; c < S_WIDTH; c++) begin
                prod[r][c] = $signed(a_pipe[r][c]) * $signed(b_pipe[r][c]);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int r = 0; r < S_HEIGHT; r++) begin
            for (int c = 0; c < S_WIDTH; c++) begin
                if (i_rst) begin
                    a_pipe[r][c]  <= '0;
                    av_pipe[r][c] <= 1'b0;
                    b_pipe[r][c]  <= '0;
                    bv_pipe[r][c] <= 1'b0;
                    acc[r][c]     <= '0;
                end else begin
                    a_pipe[r][c]  <= a_src[r][c];
                    av_pipe[r][c] <= av_src[r][c];
                    b_pipe[r][c]  <= b_src[r][c];
                    bv_pipe[r][c] <= bv_src[r][c];
                    if (clr_acc) begin
                        acc[r][c] <= '0;
                    end else if (av_pipe[r][c] && bv_pipe[r][c]) begin
                        acc[r][c] <= acc[r][c] + ACC_WIDTH'(prod[r][c]);
                    end
                end
            end
        end
    end

    always_comb begin
        o_ofmap = '0;
        if (valid_q) begin
            for (int c = 0; c < S_WIDTH; c++) begin
                if (relu_q && acc[ptr][c][ACC_WIDTH-1]) begin
                    o_ofmap[c*ACC_WIDTH +: ACC_WIDTH] = '0;
                end else begin
                    o_ofmap[c*ACC_WIDTH +: ACC_WIDTH] = acc[ptr][c];
                end
            end
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_row   = ptr;
    assign o_last  = valid_q && (ptr == RW'(S_HEIGHT-1));
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule
